// File: rtl/reaction_test_ctrl.sv
// Reaction-time test sequencer: arms the random delay, lights GO, times the
// response in ms, flags false starts/timeouts and tracks the best time.
module reaction_test_ctrl #(
  parameter int CLK_PER_MS = 25000,
  parameter int MAX_MS     = 9999,
  parameter int MS_W       = 14
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_btn,
  input  logic            react_btn,
  input  logic            delay_done,
  output logic            delay_start,
  output logic            led_go,
  output logic            busy,
  output logic [MS_W-1:0] time_ms,
  output logic            result_valid,
  output logic            timeout,
  output logic            false_start,
  output logic [MS_W-1:0] best_ms,
  output logic            new_best
);

  localparam int PS_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_PER_MS - 1);
  localparam logic [MS_W-1:0] MS_MAX  = MS_W'(MAX_MS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_GO,
    S_RESULT,
    S_FALSE
  } state_t;

  state_t            r_state;
  logic              r_start_s1, r_start_s2, r_start_prev;
  logic              r_react_s1, r_react_s2, r_react_prev;
  logic [PS_W-1:0]   r_ps;
  logic [MS_W-1:0]   r_time_ms;
  logic [MS_W-1:0]   r_best_ms;
  logic              r_delay_start, r_led_go, r_busy;
  logic              r_result_valid, r_timeout, r_false_start, r_new_best;
  logic              w_start_edge, w_react_edge;

  // Button inputs are raw asynchronous levels: two-flop sync, then rising-edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_s1   <= 1'b0;
      r_start_s2   <= 1'b0;
      r_start_prev <= 1'b0;
      r_react_s1   <= 1'b0;
      r_react_s2   <= 1'b0;
      r_react_prev <= 1'b0;
    end else begin
      r_start_s1   <= start_btn;
      r_start_s2   <= r_start_s1;
      r_start_prev <= r_start_s2;
      r_react_s1   <= react_btn;
      r_react_s2   <= r_react_s1;
      r_react_prev <= r_react_s2;
    end
  end

  assign w_start_edge = r_start_s2 & ~r_start_prev;
  assign w_react_edge = r_react_s2 & ~r_react_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_ps           <= '0;
      r_time_ms      <= '0;
      r_best_ms      <= MS_MAX;
      r_delay_start  <= 1'b0;
      r_led_go       <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_timeout      <= 1'b0;
      r_false_start  <= 1'b0;
      r_new_best     <= 1'b0;
    end else begin
      r_new_best <= 1'b0;
      case (r_state)
        S_IDLE, S_RESULT, S_FALSE: begin
          if (w_start_edge) begin
            r_state        <= S_ARMED;
            r_time_ms      <= '0;
            r_delay_start  <= 1'b1;
            r_busy         <= 1'b1;
            r_result_valid <= 1'b0;
            r_timeout      <= 1'b0;
            r_false_start  <= 1'b0;
          end
        end
        S_ARMED: begin
          // A press before the light counts as a false start even if GO arrives together.
          if (w_react_edge) begin
            r_state       <= S_FALSE;
            r_delay_start <= 1'b0;
            r_busy        <= 1'b0;
            r_false_start <= 1'b1;
          end else if (delay_done) begin
            r_state   <= S_GO;
            r_ps      <= '0;
            r_time_ms <= '0;
            r_led_go  <= 1'b1;
          end
        end
        S_GO: begin
          if (w_react_edge || (r_time_ms == MS_MAX)) begin
            r_state        <= S_RESULT;
            r_led_go       <= 1'b0;
            r_delay_start  <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b1;
            r_timeout      <= ~w_react_edge;
            if (w_react_edge && (r_time_ms < r_best_ms)) begin
              r_best_ms  <= r_time_ms;
              r_new_best <= 1'b1;
            end
          end else if (r_ps == PS_LAST) begin
            r_ps      <= '0;
            r_time_ms <= r_time_ms + MS_W'(1);
          end else begin
            r_ps <= r_ps + PS_W'(1);
          end
        end
        default: begin
          r_state        <= S_IDLE;
          r_delay_start  <= 1'b0;
          r_led_go       <= 1'b0;
          r_busy         <= 1'b0;
          r_result_valid <= 1'b0;
          r_timeout      <= 1'b0;
          r_false_start  <= 1'b0;
        end
      endcase
    end
  end

  assign delay_start  = r_delay_start;
  assign led_go       = r_led_go;
  assign busy         = r_busy;
  assign time_ms      = r_time_ms;
  assign result_valid = r_result_valid;
  assign timeout      = r_timeout;
  assign false_start  = r_false_start;
  assign best_ms      = r_best_ms;
  assign new_best     = r_new_best;

endmodule

// File: tb/tb_reaction_test_ctrl.sv
// Bench for reaction_test_ctrl: trial table, randomized trials against an
// arithmetic timing model, and reset / start-ignore sequences.
module tb_reaction_test_ctrl;

  localparam int CPM  = 4;
  localparam int MAXM = 20;
  localparam int MSW  = 14;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start_btn = 1'b0, react_btn = 1'b0, delay_done = 1'b0;
  logic           delay_start, led_go, busy, result_valid, timeout, false_start, new_best;
  logic [MSW-1:0] time_ms, best_ms;

  reaction_test_ctrl #(.CLK_PER_MS(CPM), .MAX_MS(MAXM), .MS_W(MSW)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .react_btn(react_btn),
    .delay_done(delay_done), .delay_start(delay_start), .led_go(led_go),
    .busy(busy), .time_ms(time_ms), .result_valid(result_valid),
    .timeout(timeout), .false_start(false_start), .best_ms(best_ms),
    .new_best(new_best)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int nb_cnt = 0;
  int m_best;

  always @(negedge clk) if (new_best) nb_cnt = nb_cnt + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Trial inputs are offsets from the first clock that samples the start press:
  // delay_done rises at offset dly, react_btn at offset rct (0 = never pressed).
  typedef struct {
    int dly;
    int rct;
    int exp_false;
    int exp_to;
    int exp_time;
    int exp_best;
    int exp_nb;
  } vec_t;

  vec_t tbl[10];

  // Reference: the start edge arms the test 2 clk after sampling, the react edge
  // acts 2 clk after sampling, GO begins the clk after delay_done is seen, and
  // the ms count is whole CPM-cycle periods spent in GO.
  task automatic model(input int dly, input int rct, output int f, output int to,
                       output int tm, output int nb);
    int k;
    f = 0; to = 0; tm = 0; nb = 0;
    if (rct != 0 && rct + 2 <= dly) begin
      f = 1;
    end else begin
      k = rct + 1 - dly;
      if (rct != 0 && k <= MAXM * CPM) tm = k / CPM;
      else begin to = 1; tm = MAXM; end
      if (!to && tm < m_best) begin m_best = tm; nb = 1; end
    end
  endtask

  task automatic do_trial(input string tag, input int dly, input int rct, input int ef,
                          input int eto, input int etm, input int ebest, input int enb);
    int nb0;
    bit done;
    nb0 = nb_cnt;
    done = 0;
    @(negedge clk);
    chk({tag, "_ds_low_before_arm"}, int'(delay_start), 0);
    for (int i = 0; i < 400 && !done; i++) begin
      start_btn  = (i < 3);
      delay_done = (i >= dly);
      react_btn  = (rct != 0 && i >= rct);
      @(negedge clk);
      if (i == 2)
        chk({tag, "_armed_busy_ds_nogo"}, {busy, delay_start, led_go}, 3'b110);
      if (i >= 2 && (result_valid || false_start)) done = 1;
    end
    chk({tag, "_finished"}, int'(done), 1);
    chk({tag, "_false_start"}, int'(false_start), ef);
    chk({tag, "_result_valid"}, int'(result_valid), 1 - ef);
    chk({tag, "_timeout"}, int'(timeout), eto);
    chk({tag, "_time_ms"}, int'(time_ms), etm);
    chk({tag, "_go_busy_off"}, {led_go, busy, delay_start}, 0);
    repeat (2) @(negedge clk);
    chk({tag, "_best_ms"}, int'(best_ms), ebest);
    chk({tag, "_new_best_pulses"}, nb_cnt - nb0, enb);
    chk({tag, "_outputs_hold"}, {result_valid, false_start, timeout}, {1'b0 == ef[0], ef[0], eto[0]});
    start_btn = 0; react_btn = 0; delay_done = 0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int f, to, tm, nb, dly, rct, mode;
    bit seen;
    tbl[0] = '{50, 80, 0, 0,  7, 7, 1};
    tbl[1] = '{ 5,  2, 1, 0,  0, 7, 0};
    tbl[2] = '{ 6,  4, 1, 0,  0, 7, 0};
    tbl[3] = '{20,  1, 1, 0,  0, 7, 0};
    tbl[4] = '{10,  0, 0, 1, 20, 7, 0};
    tbl[5] = '{ 8, 48, 0, 0, 10, 7, 0};
    tbl[6] = '{ 4, 16, 0, 0,  3, 3, 1};
    tbl[7] = '{ 4, 16, 0, 0,  3, 3, 0};
    tbl[8] = '{ 3, 83, 0, 1, 20, 3, 0};
    tbl[9] = '{ 3, 82, 0, 0, 20, 3, 0};

    repeat (3) @(negedge clk);
    chk("reset_flags", {delay_start, led_go, busy, result_valid, timeout, false_start, new_best}, 0);
    chk("reset_time_ms", int'(time_ms), 0);
    chk("reset_best_ms", int'(best_ms), MAXM);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("idle_no_arm", {delay_start, busy}, 0);

    for (int v = 0; v < 10; v++)
      do_trial($sformatf("tbl%0d", v), tbl[v].dly, tbl[v].rct, tbl[v].exp_false,
               tbl[v].exp_to, tbl[v].exp_time, tbl[v].exp_best, tbl[v].exp_nb);

    m_best = tbl[9].exp_best;
    for (int n = 0; n < 30; n++) begin
      dly  = $urandom_range(3, 40);
      mode = $urandom_range(0, 3);
      if (mode == 0) rct = 0;
      else if (mode == 1) rct = $urandom_range(1, dly);
      else rct = dly + $urandom_range(0, 90);
      model(dly, rct, f, to, tm, nb);
      do_trial($sformatf("rnd%0d_d%0d_r%0d", n, dly, rct), dly, rct, f, to, tm, m_best, nb);
    end

    // Into GO, press start again (must be ignored), then reset asynchronously.
    @(negedge clk);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      start_btn  = (i < 3);
      delay_done = (i >= 6);
      @(negedge clk);
      if (led_go) seen = 1;
    end
    chk("midgo_reached_go", int'(seen), 1);
    start_btn = 1;
    repeat (3) @(negedge clk);
    start_btn = 0;
    repeat (8) @(negedge clk);
    chk("midgo_start_ignored", {led_go, busy, delay_start, result_valid}, 4'b1110);
    #2 reset = 1;
    #1;
    chk("async_reset_flags", {delay_start, led_go, busy, result_valid, timeout, false_start, new_best}, 0);
    chk("async_reset_time_ms", int'(time_ms), 0);
    chk("async_reset_best_ms", int'(best_ms), MAXM);
    delay_done = 0;
    @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    do_trial("post_reset", 5, 25, 0, 0, 5, 5, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired expected completion");
    $fatal(1);
  end

endmodule
